// File: rtl/axis_video_master.sv
// AXI4-Stream video master: elastic FIFO with raster framing (TUSER/TLAST).
// Pixels are tagged with sof/eol/eof at accept time and replayed at send.
module axis_video_master #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       pix_valid,
  input  logic [DATA_W-1:0]          pix_data,
  input  logic                       pix_sof,
  output logic                       pix_ready,
  output logic [DATA_W-1:0]          TDATA,
  output logic                       TVALID,
  input  logic                       TREADY,
  output logic                       TLAST,
  output logic                       TUSER,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       frame_done
);

  localparam int EW = DATA_W + 3;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int XW = $clog2(LINE_W);
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [XW-1:0] XMAX = XW'(LINE_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(FRAME_H - 1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [XW-1:0] x_q, x_d, pos_x;
  logic [YW-1:0] y_q, y_d, pos_y;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          accept, send;
  logic          f_sof, f_eol, f_eof;
  logic [EW-1:0] entry, head;

  assign head   = mem_q[rd_ptr_q];
  assign TVALID = (level_q != '0);
  assign TDATA  = TVALID ? head[DATA_W-1:0] : '0;
  assign TLAST  = TVALID & head[DATA_W];
  assign TUSER  = TVALID & head[DATA_W+1];
  assign level      = level_q;
  assign pix_ready  = ready_q;
  assign frame_done = done_q;

  assign accept = pix_valid & ready_q;
  assign send   = TVALID & TREADY;

  // Resync overrides the running raster position.
  assign pos_x = pix_sof ? '0 : x_q;
  assign pos_y = pix_sof ? '0 : y_q;
  assign f_sof = (pos_x == '0) && (pos_y == '0);
  assign f_eol = (pos_x == XMAX);
  assign f_eof = f_eol && (pos_y == YMAX);
  assign entry = {f_eof, f_sof, f_eol, pix_data};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    x_d      = x_q;
    y_d      = y_q;
    level_d  = level_q + LW'(accept) - LW'(send);
    ready_d  = (level_d < LW'(DEPTH));
    done_d   = send & head[DATA_W+2];
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (f_eol) begin
        x_d = '0;
        y_d = (pos_y == YMAX) ? '0 : pos_y + YW'(1);
      end else begin
        x_d = pos_x + XW'(1);
        y_d = pos_y;
      end
    end
    if (send) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

endmodule

// File: tb/tb_axis_video_master.sv
// Directed bench for axis_video_master (DEPTH=4, 4x2 raster).
// Stream, back-pressure, resync, async reset and random stall phases.
module tb_axis_video_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        pix_valid;
  logic [31:0] pix_data;
  logic        pix_sof;
  logic        pix_ready;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TREADY;
  logic        TLAST;
  logic        TUSER;
  logic [2:0]  level;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  axis_video_master #(
    .DATA_W(32), .DEPTH(4), .LINE_W(4), .FRAME_H(2)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_ready(pix_ready),
    .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY),
    .TLAST(TLAST), .TUSER(TUSER),
    .level(level), .frame_done(frame_done)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int n_in, n_out, fd_cnt, guard;
    logic acc, snd, hold;
    logic [31:0] p_data;
    logic p_user, p_last;

    ARESETn = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    pix_sof = 1'b0;
    TREADY = 1'b0;
    #3;
    chk("rst_tvalid", TVALID, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", pix_ready, 0);
    chk("rst_tdata", TDATA, 0);
    chk("rst_tuser", TUSER, 0);
    chk("rst_tlast", TLAST, 0);
    chk("rst_fdone", frame_done, 0);
    #9 ARESETn = 1'b1;
    step();
    chk("ready_after_rst", pix_ready, 1);

    // stream one frame 0x10..0x17
    TREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1;
      pix_data = 32'h10 + i;
      if (i == 0) chk("latency_pre", TVALID, 0);
      step();
      chk("s_tvalid", TVALID, 1);
      chk("s_tdata", TDATA, 32'h10 + i);
      chk("s_tuser", TUSER, i == 0);
      chk("s_tlast", TLAST, (i % 4) == 3);
      chk("s_fdone", frame_done, 0);
      chk("s_level", level, 1);
    end
    pix_valid = 1'b0;
    step();
    chk("s_fdone_pulse", frame_done, 1);
    chk("s_empty", TVALID, 0);
    step();
    chk("s_fdone_once", frame_done, 0);

    // back-pressure
    TREADY = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_data = 32'h20 + i;
      chk("bp_ready", pix_ready, 1);
      step();
      chk("bp_level", level, i + 1);
    end
    chk("bp_full_ready", pix_ready, 0);
    chk("bp_head", TDATA, 32'h20);
    chk("bp_tuser", TUSER, 1);
    pix_data = 32'h24;
    step();
    step();
    chk("bp_hold_level", level, 4);
    chk("bp_hold_data", TDATA, 32'h20);
    chk("bp_hold_ready", pix_ready, 0);
    TREADY = 1'b1;
    step();
    chk("full_sim_level", level, 3);
    chk("full_sim_ready", pix_ready, 1);
    chk("full_sim_head", TDATA, 32'h21);
    step();
    chk("acc_after_full", level, 3);
    chk("order_22", TDATA, 32'h22);
    pix_valid = 1'b0;
    step();
    chk("order_23", TDATA, 32'h23);
    chk("order_23_last", TLAST, 1);
    step();
    chk("order_24", TDATA, 32'h24);
    chk("order_24_user", TUSER, 0);
    chk("order_24_last", TLAST, 0);
    step();
    chk("bp_drained", TVALID, 0);

    // resync on the 6th pixel of the frame
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      pix_sof = (i == 0);
      pix_data = 32'h30 + i;
      step();
      chk("rs_tdata", TDATA, 32'h30 + i);
      chk("rs_tuser", TUSER, i == 0);
      chk("rs_tlast", TLAST, i == 3);
    end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    step();
    chk("rs_drained", TVALID, 0);

    // asynchronous reset with 3 pixels buffered
    TREADY = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_data = 32'h40 + i;
      step();
    end
    pix_valid = 1'b0;
    chk("mr_level3", level, 3);
    #2 ARESETn = 1'b0;
    #1;
    chk("mr_tvalid", TVALID, 0);
    chk("mr_level", level, 0);
    chk("mr_ready", pix_ready, 0);
    chk("mr_tdata", TDATA, 0);
    #2 ARESETn = 1'b1;
    step();
    chk("mr_ready_up", pix_ready, 1);
    TREADY = 1'b1;
    pix_valid = 1'b1;
    pix_data = 32'h50;
    step();
    chk("mr_tdata50", TDATA, 32'h50);
    chk("mr_tuser", TUSER, 1);
    chk("mr_tlast", TLAST, 0);
    pix_valid = 1'b0;
    step();
    chk("mr_fdone", frame_done, 0);
    chk("mr_drained", TVALID, 0);

    // random stalls over 3 frames (0x50 was pixel 0)
    n_in = 1;
    n_out = 1;
    fd_cnt = 0;
    guard = 0;
    hold = 1'b0;
    p_data = '0;
    p_user = 1'b0;
    p_last = 1'b0;
    while ((n_in < 24 || n_out < 24) && guard < 600) begin
      guard++;
      pix_valid = (n_in < 24) && ($urandom_range(0, 1) == 1);
      pix_data = 32'h100 + n_in;
      TREADY = ($urandom_range(0, 1) == 1);
      chk("rn_level", level, n_in - n_out);
      chk("rn_level_max", level <= 4, 1);
      if (TVALID) begin
        chk("rn_tdata", TDATA, 32'h100 + n_out);
        chk("rn_tuser", TUSER, (n_out % 8) == 0);
        chk("rn_tlast", TLAST, (n_out % 4) == 3);
      end
      if (hold) begin
        chk("rn_hold_valid", TVALID, 1);
        chk("rn_hold_data", TDATA, p_data);
        chk("rn_hold_user", TUSER, p_user);
        chk("rn_hold_last", TLAST, p_last);
      end
      acc = pix_valid && pix_ready;
      snd = TVALID && TREADY;
      hold = TVALID && !TREADY;
      p_data = TDATA;
      p_user = TUSER;
      p_last = TLAST;
      step();
      if (acc) n_in++;
      if (snd) n_out++;
      if (frame_done) fd_cnt++;
    end
    pix_valid = 1'b0;
    chk("rn_in_count", n_in, 24);
    chk("rn_out_count", n_out, 24);
    chk("rn_fdone_count", fd_cnt, 3);
    chk("rn_empty", TVALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
